// File: rtl/scan_pair_mux_pkg.sv
// scan_pair_mux_pkg: shared state type and modulo-increment helper for scan_pair_mux
package scan_pair_mux_pkg;

    typedef enum logic {MANUAL, SCAN} state_t;

    function automatic int unsigned next_idx(input int unsigned p, input int unsigned n);
        return (p + 1 >= n) ? 0 : p + 1;
    endfunction

endpackage

// File: rtl/scan_pair_mux_if.sv
// scan_pair_mux_if: channel bus, pair-select controls and status outputs of scan_pair_mux
interface scan_pair_mux_if #(
    parameter int WIDTH  = 4,
    parameter int NUM_IN = 4
) ();
    localparam int SEL_W = $clog2(NUM_IN);

    logic [NUM_IN*WIDTH-1:0] DIN;
    logic [SEL_W-1:0]        SE;
    logic                    SE_LOAD;
    logic                    AUTO;
    logic                    HOLD;
    logic [WIDTH-1:0]        M;
    logic [WIDTH-1:0]        N;
    logic [SEL_W-1:0]        PTR;
    logic                    WRAP;
    logic                    ERR;

    modport master (output DIN, SE, SE_LOAD, AUTO, HOLD, input M, N, PTR, WRAP, ERR);
    modport slave  (input DIN, SE, SE_LOAD, AUTO, HOLD, output M, N, PTR, WRAP, ERR);
endinterface

// File: rtl/scan_pair_mux_dwell_counter.sv
// dwell_counter: counts 0..DWELL-1 while enabled, tick marks the last count
module dwell_counter #(
    parameter int DWELL = 10
) (
    input  logic CLK,
    input  logic RST,
    input  logic clr,
    input  logic en,
    output logic tick
);
    localparam int CW = DWELL > 1 ? $clog2(DWELL) : 1;

    logic [CW-1:0] r_cnt;

    assign tick = (r_cnt == CW'(DWELL - 1));

    // clear wins over count; the count rolls back to 0 after its last value
    always_ff @(posedge CLK) begin
        if (RST || clr)
            r_cnt <= '0;
        else if (en)
            r_cnt <= tick ? '0 : r_cnt + 1'b1;
    end
endmodule

// File: rtl/scan_pair_mux.sv
// scan_pair_mux: registered adjacent-pair selector with manual load and round-robin auto-scan
module scan_pair_mux
    import scan_pair_mux_pkg::*;
#(
    parameter int WIDTH  = 4,
    parameter int NUM_IN = 4,
    parameter int DWELL  = 10
) (
    input logic           CLK,
    input logic           RST,
    scan_pair_mux_if.slave bus
);
    localparam int SEL_W   = $clog2(NUM_IN);
    localparam int NUM_PAD = 1 << SEL_W;

    state_t           r_state;
    state_t           w_state_nxt;
    logic [SEL_W-1:0] r_ptr;
    logic [SEL_W-1:0] w_ptr_nxt;
    logic [SEL_W-1:0] w_ptr_inc;
    logic [WIDTH-1:0] r_m;
    logic [WIDTH-1:0] r_n;
    logic             r_wrap;
    logic             r_err;
    logic             w_load_ok;
    logic             w_load_bad;
    logic             w_adv;
    logic             w_cnt_en;
    logic             w_cnt_clr;
    logic             w_tick;
    logic [WIDTH-1:0] w_ch [NUM_PAD];

    // unpack channels; pointer codes beyond NUM_IN-1 map to zero and are never selected
    genvar g;
    for (g = 0; g < NUM_PAD; g++) begin : g_ch
        if (g < NUM_IN) begin : g_real
            assign w_ch[g] = bus.DIN[g*WIDTH +: WIDTH];
        end else begin : g_pad
            assign w_ch[g] = '0;
        end
    end

    assign w_ptr_inc = SEL_W'(next_idx(32'(r_ptr), NUM_IN));

    dwell_counter #(.DWELL(DWELL)) u_dwell (
        .CLK  (CLK),
        .RST  (RST),
        .clr  (w_cnt_clr),
        .en   (w_cnt_en),
        .tick (w_tick)
    );

    // mode follows AUTO; priority HOLD > SE_LOAD > auto advance decides pointer and counter
    always_comb begin
        w_state_nxt = bus.AUTO ? SCAN : MANUAL;
        w_load_ok   = bus.SE_LOAD && ({1'b0, bus.SE} < (SEL_W+1)'(NUM_IN));
        w_load_bad  = bus.SE_LOAD && !w_load_ok;
        w_cnt_en    = !bus.HOLD && !bus.SE_LOAD && r_state == SCAN;
        w_adv       = w_cnt_en && w_tick;
        w_cnt_clr   = !bus.HOLD && (w_load_ok || r_state == MANUAL || w_state_nxt == MANUAL);
        w_ptr_nxt   = bus.HOLD ? r_ptr : w_load_ok ? bus.SE : w_adv ? w_ptr_inc : r_ptr;
    end

    // mode register
    always_ff @(posedge CLK) begin
        if (RST)
            r_state <= MANUAL;
        else
            r_state <= w_state_nxt;
    end

    // pointer, pair outputs from the pre-edge pointer, wrap pulse and sticky error
    always_ff @(posedge CLK) begin
        if (RST) begin
            r_ptr  <= '0;
            r_m    <= '0;
            r_n    <= '0;
            r_wrap <= 1'b0;
            r_err  <= 1'b0;
        end else begin
            if (!bus.HOLD) begin
                r_ptr <= w_ptr_nxt;
                r_m   <= w_ch[r_ptr];
                r_n   <= w_ch[w_ptr_inc];
            end
            r_wrap <= w_adv && r_ptr == SEL_W'(NUM_IN - 1);
            r_err  <= r_err || (!bus.HOLD && w_load_bad);
        end
    end

    assign bus.M    = r_m;
    assign bus.N    = r_n;
    assign bus.PTR  = r_ptr;
    assign bus.WRAP = r_wrap;
    assign bus.ERR  = r_err;
endmodule

// File: tb/tb_scan_pair_mux.sv
// tb_scan_pair_mux: directed checks of reset, manual select, auto-scan, hold, illegal load and jump
module tb_scan_pair_mux;
    logic clk = 1'b0;
    logic rst = 1'b1;
    int   n_cmp = 0;
    int   n_err = 0;

    logic [3:0] ch4 [4] = '{4'b1100, 4'b1010, 4'b1001, 4'b0110};

    always #5 clk = ~clk;

    scan_pair_mux_if #(.WIDTH(4), .NUM_IN(4)) if4 ();
    scan_pair_mux_if #(.WIDTH(4), .NUM_IN(3)) if3 ();

    scan_pair_mux #(.WIDTH(4), .NUM_IN(4), .DWELL(3)) u4 (.CLK(clk), .RST(rst), .bus(if4));
    scan_pair_mux #(.WIDTH(4), .NUM_IN(3), .DWELL(3)) u3 (.CLK(clk), .RST(rst), .bus(if3));

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        step();
        step();
        if (if4.M !== 4'b0000) begin n_err++; $display("FAIL reset_M got %b want 0000", if4.M); end
        n_cmp++;
        if (if4.N !== 4'b0000) begin n_err++; $display("FAIL reset_N got %b want 0000", if4.N); end
        n_cmp++;
        if (if4.PTR !== 2'd0) begin n_err++; $display("FAIL reset_PTR got %0d want 0", if4.PTR); end
        n_cmp++;
        if (if4.WRAP !== 1'b0 || if4.ERR !== 1'b0) begin n_err++; $display("FAIL reset_flags got wrap=%b err=%b want 0 0", if4.WRAP, if4.ERR); end
        n_cmp++;
        rst = 1'b0;
        step();
        if (if4.M !== 4'b1100 || if4.N !== 4'b1010) begin n_err++; $display("FAIL release_pair got %b/%b want 1100/1010", if4.M, if4.N); end
        n_cmp++;
    endtask

    task automatic test_manual();
        if4.SE = 2'd2; if4.SE_LOAD = 1'b1;
        step();
        if4.SE_LOAD = 1'b0;
        if (if4.PTR !== 2'd2 || if4.M !== 4'b1100) begin n_err++; $display("FAIL load2_ptr got ptr=%0d M=%b want 2 1100", if4.PTR, if4.M); end
        n_cmp++;
        step();
        if (if4.M !== 4'b1001 || if4.N !== 4'b0110) begin n_err++; $display("FAIL load2_pair got %b/%b want 1001/0110", if4.M, if4.N); end
        n_cmp++;
        if4.SE = 2'd3; if4.SE_LOAD = 1'b1;
        step();
        if4.SE_LOAD = 1'b0;
        step();
        if (if4.PTR !== 2'd3 || if4.M !== 4'b0110 || if4.N !== 4'b1100) begin n_err++; $display("FAIL load3_pair got ptr=%0d %b/%b want 3 0110/1100", if4.PTR, if4.M, if4.N); end
        n_cmp++;
    endtask

    task automatic test_auto_scan();
        logic [1:0] exp_ptr;
        logic [1:0] prev;
        int wraps;
        wraps = 0;
        if4.AUTO = 1'b1; if4.SE = 2'd0; if4.SE_LOAD = 1'b1;
        step();
        if4.SE_LOAD = 1'b0;
        if (if4.PTR !== 2'd0 || if4.M !== 4'b0110) begin n_err++; $display("FAIL auto_start got ptr=%0d M=%b want 0 0110", if4.PTR, if4.M); end
        n_cmp++;
        prev = 2'd0;
        for (int k = 1; k <= 12; k++) begin
            step();
            exp_ptr = 2'((k / 3) % 4);
            if (if4.WRAP === 1'b1) wraps++;
            if (if4.PTR !== exp_ptr) begin n_err++; $display("FAIL scan_ptr k=%0d got %0d want %0d", k, if4.PTR, exp_ptr); end
            n_cmp++;
            if (if4.M !== ch4[prev]) begin n_err++; $display("FAIL scan_M k=%0d got %b want %b", k, if4.M, ch4[prev]); end
            n_cmp++;
            if (if4.WRAP !== (k == 12)) begin n_err++; $display("FAIL scan_wrap k=%0d got %b want %b", k, if4.WRAP, (k == 12)); end
            n_cmp++;
            prev = exp_ptr;
        end
        if (wraps !== 1) begin n_err++; $display("FAIL wrap_count got %0d want 1", wraps); end
        n_cmp++;
        for (int k = 0; k < 4; k++) step();
        if (if4.PTR !== 2'd1 || if4.WRAP !== 1'b0) begin n_err++; $display("FAIL scan_second_lap got ptr=%0d wrap=%b want 1 0", if4.PTR, if4.WRAP); end
        n_cmp++;
    endtask

    task automatic test_hold();
        if4.HOLD = 1'b1; if4.SE = 2'd3; if4.SE_LOAD = 1'b1;
        for (int h = 0; h < 5; h++) begin
            step();
            if4.SE_LOAD = 1'b0;
            if (if4.PTR !== 2'd1 || if4.M !== 4'b1010 || if4.N !== 4'b1001) begin n_err++; $display("FAIL hold_frozen h=%0d got ptr=%0d %b/%b want 1 1010/1001", h, if4.PTR, if4.M, if4.N); end
            n_cmp++;
            if (if4.WRAP !== 1'b0 || if4.ERR !== 1'b0) begin n_err++; $display("FAIL hold_flags h=%0d got wrap=%b err=%b want 0 0", h, if4.WRAP, if4.ERR); end
            n_cmp++;
        end
        if4.HOLD = 1'b0;
        step();
        if (if4.PTR !== 2'd1) begin n_err++; $display("FAIL hold_resume1 got %0d want 1", if4.PTR); end
        n_cmp++;
        step();
        if (if4.PTR !== 2'd2 || if4.M !== 4'b1010) begin n_err++; $display("FAIL hold_resume2 got ptr=%0d M=%b want 2 1010", if4.PTR, if4.M); end
        n_cmp++;
    endtask

    task automatic test_jump();
        step();
        if4.SE = 2'd0; if4.SE_LOAD = 1'b1;
        step();
        if4.SE_LOAD = 1'b0;
        if (if4.PTR !== 2'd0 || if4.WRAP !== 1'b0) begin n_err++; $display("FAIL jump_ptr got ptr=%0d wrap=%b want 0 0", if4.PTR, if4.WRAP); end
        n_cmp++;
        step();
        if (if4.WRAP !== 1'b0) begin n_err++; $display("FAIL jump_no_wrap got %b want 0", if4.WRAP); end
        n_cmp++;
        step();
        if (if4.PTR !== 2'd0) begin n_err++; $display("FAIL jump_dwell2 got %0d want 0", if4.PTR); end
        n_cmp++;
        step();
        if (if4.PTR !== 2'd1) begin n_err++; $display("FAIL jump_dwell3 got %0d want 1", if4.PTR); end
        n_cmp++;
    endtask

    task automatic test_illegal_load();
        if3.SE = 2'd1; if3.SE_LOAD = 1'b1;
        step();
        if (if3.PTR !== 2'd1 || if3.ERR !== 1'b0) begin n_err++; $display("FAIL n3_load1 got ptr=%0d err=%b want 1 0", if3.PTR, if3.ERR); end
        n_cmp++;
        if3.SE = 2'd3;
        step();
        if3.SE_LOAD = 1'b0;
        if (if3.PTR !== 2'd1 || if3.ERR !== 1'b1) begin n_err++; $display("FAIL n3_illegal got ptr=%0d err=%b want 1 1", if3.PTR, if3.ERR); end
        n_cmp++;
        step();
        if (if3.ERR !== 1'b1) begin n_err++; $display("FAIL n3_err_sticky got %b want 1", if3.ERR); end
        n_cmp++;
        if3.SE = 2'd2; if3.SE_LOAD = 1'b1;
        step();
        if3.SE_LOAD = 1'b0;
        step();
        if (if3.M !== 4'b1001 || if3.N !== 4'b1100 || if3.ERR !== 1'b1) begin n_err++; $display("FAIL n3_wrap_pair got %b/%b err=%b want 1001/1100 1", if3.M, if3.N, if3.ERR); end
        n_cmp++;
    endtask

    task automatic test_reset_mid_scan();
        rst = 1'b1;
        if4.HOLD = 1'b1; if4.AUTO = 1'b1; if4.SE = 2'd2; if4.SE_LOAD = 1'b1;
        step();
        if (if4.PTR !== 2'd0 || if4.M !== 4'b0000 || if4.N !== 4'b0000 || if4.WRAP !== 1'b0) begin n_err++; $display("FAIL mid_reset got ptr=%0d %b/%b wrap=%b want 0 0000/0000 0", if4.PTR, if4.M, if4.N, if4.WRAP); end
        n_cmp++;
        if (if3.ERR !== 1'b0) begin n_err++; $display("FAIL mid_reset_err got %b want 0", if3.ERR); end
        n_cmp++;
        rst = 1'b0;
        if4.HOLD = 1'b0; if4.AUTO = 1'b0; if4.SE_LOAD = 1'b0;
        step();
        if (if4.PTR !== 2'd0 || if4.M !== 4'b1100) begin n_err++; $display("FAIL post_reset got ptr=%0d M=%b want 0 1100", if4.PTR, if4.M); end
        n_cmp++;
    endtask

    initial begin
        if4.DIN = {4'b0110, 4'b1001, 4'b1010, 4'b1100};
        if4.SE = '0; if4.SE_LOAD = 1'b0; if4.AUTO = 1'b0; if4.HOLD = 1'b0;
        if3.DIN = {4'b1001, 4'b1010, 4'b1100};
        if3.SE = '0; if3.SE_LOAD = 1'b0; if3.AUTO = 1'b0; if3.HOLD = 1'b0;
        test_reset();
        test_manual();
        test_auto_scan();
        test_hold();
        test_jump();
        test_illegal_load();
        test_reset_mid_scan();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule

// File: doc/scan_pair_mux.md
# scan_pair_mux

Parametrised, registered successor to the team's 4-to-2 multiplexer. Selects a pair of adjacent channels from NUM_IN input channels of WIDTH bits onto outputs M and N. Pair selection is either loaded manually from SE or advanced automatically by an internal round-robin scanner with a programmable dwell time. Sits between the channel data sources and downstream display/compare logic. Freeze and wrap-notification behaviour are new relative to the combinational 4-to-2 mux.

## Interface
- WIDTH, 4: bits per channel.
- NUM_IN, 4: channel count; at least 2.
- DWELL, 10: clock cycles each pointer value is held in auto-scan mode; at least 1.
- SEL_W (localparam): $clog2(NUM_IN).

Ports:
- CLK  in  1  single clock, rising edge.
- RST  in  1  synchronous, active-high reset.
- DIN  in  NUM_IN*WIDTH  packed channels; channel i is DIN[i*WIDTH +: WIDTH].
- SE  in  SEL_W  manual pointer value.
- SE_LOAD  in  1  load SE into the pointer this cycle.
- AUTO  in  1  1 = auto-scan, 0 = manual.
- HOLD  in  1  freeze pointer, dwell counter and outputs.
- M  out  WIDTH  registered channel[PTR].
- N  out  WIDTH  registered channel[(PTR+1) mod NUM_IN].
- PTR  out  SEL_W  current pointer.
- WRAP  out  1  one-cycle pulse when auto-scan wraps PTR from NUM_IN-1 to 0.
- ERR  out  1  sticky flag, set when SE_LOAD has SE ≥ NUM_IN; cleared only by RST.

## Operation
- FSM states are MANUAL and SCAN.
  - MANUAL→SCAN when AUTO=1.
  - SCAN→MANUAL when AUTO=0.
  - The transition happens on the clock edge where AUTO is sampled.
  - Entering SCAN clears the dwell counter.
- Per-edge priority: RST > HOLD > SE_LOAD > auto advance.
- SE_LOAD, legal value (SE < NUM_IN): PTR ← SE and the dwell counter clears. This works in both states; in SCAN it acts as a jump.
- SE_LOAD, illegal value (SE ≥ NUM_IN): PTR is unchanged and ERR ← 1.
- Auto advance (SCAN only, no HOLD, no SE_LOAD):
  - The dwell counter counts 0..DWELL-1.
  - At DWELL-1 the counter returns to 0 and PTR ← PTR+1 mod NUM_IN.
  - On the wrap from NUM_IN-1 to 0, WRAP = 1 for one cycle.
- In MANUAL the dwell counter is held at 0 and PTR changes only through SE_LOAD.
- Every edge without HOLD: M ← channel[PTR], N ← channel[(PTR+1) mod NUM_IN], both using the PTR value before the edge.
- Modulo wrap for N is explicit; this matters when NUM_IN is not a power of two.
- HOLD: M, N, PTR and the counter keep their values and WRAP = 0. A SE_LOAD during HOLD is discarded and does not set ERR.
- Reset values: PTR=0, M=0, N=0, WRAP=0, ERR=0, counter=0, state=MANUAL.

## Timing
- DIN→M/N latency is 1 cycle.
- SE_LOAD at edge t updates PTR at t. M/N reflect the new pair at edge t+1.
- Auto scan: PTR changes every DWELL cycles. WRAP is asserted in the same cycle that PTR reads 0 after a wrap.
- With DWELL=1, PTR advances on every edge.
- RST asserted mid-scan: all outputs return to reset values on the next edge, regardless of HOLD, AUTO or SE_LOAD.
- AUTO and SE_LOAD on the same edge: the state goes to SCAN, PTR ← SE, and the counter clears.

## Structure
- Package scan_pair_mux_pkg holds:
  - the state enum (MANUAL, SCAN);
  - the function giving (p+1) mod n.
- Sub-module dwell_counter:
  - parameter DWELL;
  - inputs clr and en;
  - output tick, asserted at DWELL-1.
- The top level holds the FSM, the pointer, the output registers and the ERR/WRAP logic.

## Test plan
All scenarios use WIDTH=4 and NUM_IN=4, with channels 0..3 = 1100, 1010, 1001, 0110.
- Reset: assert RST for 2 cycles → M=0000, N=0000, PTR=0, WRAP=0, ERR=0. After release in MANUAL → M=1100, N=1010 one cycle later.
- Manual select: SE_LOAD with SE=2 → PTR=2, then M=1001, N=0110. Then SE=3 → M=0110, N=1100 (N wraps).
- Auto scan, DWELL=3: AUTO=1 from PTR=0.
  - PTR steps 0→1→2→3→0, changing every 3 cycles.
  - WRAP pulses exactly once per 12 cycles, on the 3→0 step.
  - M follows 1100, 1010, 1001, 0110.
- HOLD mid-scan: assert HOLD for 5 cycles at PTR=1 → PTR, M and N are frozen and WRAP=0. After release the counter resumes from its frozen count.
- Illegal load: with NUM_IN=3, SE_LOAD with SE=3 → PTR unchanged and ERR=1 and stays set until RST.
- Jump during scan: SE_LOAD with SE=0 at PTR=2 while in SCAN → PTR=0 with no WRAP pulse. The next advance occurs DWELL cycles later.
